// File: rtl/xil_lfsr_pkg.sv
// xil_lfsr_pkg
// Shared definitions for the parallel LFSR word generator.
//   lfsr_state_e : control FSM encoding (IDLE / PRIME / RUN), 2 bits
//   LFSRn_TAPS   : maximal-length feedback masks, bit k set means state[k]
//                  is XORed into the feedback bit
package xil_lfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } lfsr_state_e;

   // x^7  + x^6  + 1
   localparam logic [6:0]  LFSR7_TAPS  = 7'h60;
   // x^15 + x^14 + 1
   localparam logic [14:0] LFSR15_TAPS = 15'h6000;
   // x^22 + x^21 + 1
   localparam logic [21:0] LFSR22_TAPS = 22'h30_0000;
   // x^33 + x^20 + 1
   localparam logic [32:0] LFSR33_TAPS = 33'h1_0008_0000;

endpackage

// File: rtl/xil_lfsr_step.sv
// xil_lfsr_step
// Combinational unroll of NBITS Fibonacci LFSR steps.
// One step: fb = ^(state & taps); state = {state[WIDTH-2:0], fb}.
// Ports:
//   i_state : current LFSR state
//   i_taps  : feedback mask
//   o_next  : state after NBITS steps
//   o_word  : generated bits, first feedback bit in o_word[0]
module xil_lfsr_step #(
   parameter int WIDTH = 33,
   parameter int NBITS = 8
) (
   input  logic [WIDTH-1:0] i_state,
   input  logic [WIDTH-1:0] i_taps,
   output logic [WIDTH-1:0] o_next,
   output logic [NBITS-1:0] o_word
);

   logic [WIDTH-1:0] w_state;
   logic [NBITS-1:0] w_word;
   logic             w_fb;

   // Walk the shift register NBITS times within one cycle, collecting
   // each feedback bit in generation order.
   always_comb begin
      w_state = i_state;
      w_word  = '0;
      w_fb    = 1'b0;
      for (int k = 0; k < NBITS; k++) begin
         w_fb      = ^(w_state & i_taps);
         w_word[k] = w_fb;
         w_state   = {w_state[WIDTH-2:0], w_fb};
      end
      o_next = w_state;
      o_word = w_word;
   end

endmodule

// File: rtl/xil_par_lfsr.sv
// xil_par_lfsr
// Parallel LFSR word source with a valid/ready output stream.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i             : leave IDLE and begin generating
//   stop_i              : return to IDLE after the next accepted word
//   seed_load_i, seed_i : load the LFSR state (IDLE only, zero -> SEED)
//   out_ready_i         : consumer accept
//   out_valid_o         : word available
//   out_data_o          : NBITS-bit word
//   state_o             : current LFSR state
//   running_o           : high in PRIME and RUN
//   lockup_o            : sticky, a zero seed was replaced by SEED
module xil_par_lfsr
   import xil_lfsr_pkg::*;
#(
   parameter int               WIDTH     = 33,
   parameter logic [WIDTH-1:0] TAPS      = LFSR33_TAPS,
   parameter int               NBITS     = 8,
   parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
   parameter string            AUTOSTART = "FALSE"
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             seed_load_i,
   input  logic [WIDTH-1:0] seed_i,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [NBITS-1:0] out_data_o,
   output logic [WIDTH-1:0] state_o,
   output logic             running_o,
   output logic             lockup_o
);

   localparam lfsr_state_e RESET_FSM = (AUTOSTART == "TRUE") ? ST_PRIME : ST_IDLE;

   lfsr_state_e      r_fsm;
   logic [WIDTH-1:0] r_state;
   logic [NBITS-1:0] r_data;
   logic             r_valid;
   logic             r_lockup;
   logic             r_stopPend;
   logic [WIDTH-1:0] w_next;
   logic [NBITS-1:0] w_word;

   xil_lfsr_step #(
      .WIDTH (WIDTH),
      .NBITS (NBITS)
   ) u_step (
      .i_state (r_state),
      .i_taps  (TAPS),
      .o_next  (w_next),
      .o_word  (w_word)
   );

   // Control FSM and datapath registers. The state only advances when a
   // word is produced (PRIME, or a RUN handshake), so an unaccepted word
   // and the state behind it stay frozen. A zero seed is swapped for SEED
   // so the register can never fall into the all-zero lockup state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fsm      <= RESET_FSM;
         r_state    <= SEED;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_lockup   <= 1'b0;
         r_stopPend <= 1'b0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (seed_load_i) begin
                  if (seed_i == '0) begin
                     r_state  <= SEED;
                     r_lockup <= 1'b1;
                  end else begin
                     r_state <= seed_i;
                  end
               end
               if (start_i) begin
                  r_fsm <= ST_PRIME;
               end
            end
            ST_PRIME: begin
               r_state <= w_next;
               r_data  <= w_word;
               r_valid <= 1'b1;
               r_fsm   <= ST_RUN;
               if (stop_i) begin
                  r_stopPend <= 1'b1;
               end
            end
            ST_RUN: begin
               if (r_valid && out_ready_i) begin
                  r_state <= w_next;
                  r_data  <= w_word;
                  if (r_stopPend || stop_i) begin
                     r_fsm      <= ST_IDLE;
                     r_valid    <= 1'b0;
                     r_stopPend <= 1'b0;
                  end
               end else if (stop_i) begin
                  r_stopPend <= 1'b1;
               end
            end
            default: begin
               r_fsm   <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid_o = r_valid;
   assign out_data_o  = r_data;
   assign state_o     = r_state;
   assign running_o   = (r_fsm != ST_IDLE);
   assign lockup_o    = r_lockup;

endmodule

// File: tb/tb_xil_par_lfsr.sv
// tb_xil_par_lfsr
// Directed bench for xil_par_lfsr using the 7-bit x^7+x^6+1 polynomial.
//   dut8 : NBITS=8, manual start, driven from a vector table
//   dut1 : NBITS=1, used for the bit sequence and the period
//   dutA : NBITS=8, AUTOSTART="TRUE", shares reset and ready with dut8
module tb_xil_par_lfsr;

   logic clk = 1'b0;
   logic rst;
   logic start, stop, seedLoad, ready;
   logic [6:0] seed;
   logic start1, ready1;

   logic       valid8, running8, lockup8;
   logic [7:0] data8;
   logic [6:0] state8;
   logic       valid1, running1, lockup1;
   logic [0:0] data1;
   logic [6:0] state1;
   logic       validA, runningA, lockupA;
   logic [7:0] dataA;
   logic [6:0] stateA;

   int nChecks = 0;
   int nPass   = 0;

   always #5 clk = ~clk;

   xil_par_lfsr #(.WIDTH(7), .TAPS(7'h60), .NBITS(8), .SEED(7'h01), .AUTOSTART("FALSE")) dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
      .seed_load_i(seedLoad), .seed_i(seed), .out_ready_i(ready),
      .out_valid_o(valid8), .out_data_o(data8), .state_o(state8),
      .running_o(running8), .lockup_o(lockup8));

   xil_par_lfsr #(.WIDTH(7), .TAPS(7'h60), .NBITS(1), .SEED(7'h01), .AUTOSTART("FALSE")) dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start1), .stop_i(1'b0),
      .seed_load_i(1'b0), .seed_i(7'h00), .out_ready_i(ready1),
      .out_valid_o(valid1), .out_data_o(data1), .state_o(state1),
      .running_o(running1), .lockup_o(lockup1));

   xil_par_lfsr #(.WIDTH(7), .TAPS(7'h60), .NBITS(8), .SEED(7'h01), .AUTOSTART("TRUE")) dutA (
      .clk_i(clk), .rst_i(rst), .start_i(1'b0), .stop_i(1'b0),
      .seed_load_i(1'b0), .seed_i(7'h00), .out_ready_i(ready),
      .out_valid_o(validA), .out_data_o(dataA), .state_o(stateA),
      .running_o(runningA), .lockup_o(lockupA));

   typedef struct {
      logic       start;
      logic       stop;
      logic       seedLoad;
      logic [6:0] seed;
      logic       ready;
      logic       expValid;
      logic [7:0] expData;
      logic [6:0] expState;
      logic       expLockup;
      logic       expRunning;
   } vec_t;

   vec_t vecs[15];

   // One clock: inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic iStart, input logic iStop, input logic iLoad,
                                input logic [6:0] iSeed, input logic iReady);
      start    = iStart;
      stop     = iStop;
      seedLoad = iLoad;
      seed     = iSeed;
      ready    = iReady;
      tick();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         nPass++;
      end
   endtask

   task automatic runRows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].seedLoad, vecs[i].seed, vecs[i].ready);
         checkOutput($sformatf("row%0d valid", i),   64'(valid8),   64'(vecs[i].expValid));
         checkOutput($sformatf("row%0d data", i),    64'(data8),    64'(vecs[i].expData));
         checkOutput($sformatf("row%0d state", i),   64'(state8),   64'(vecs[i].expState));
         checkOutput($sformatf("row%0d lockup", i),  64'(lockup8),  64'(vecs[i].expLockup));
         checkOutput($sformatf("row%0d running", i), 64'(running8), 64'(vecs[i].expRunning));
      end
   endtask

   initial begin
      logic [7:0] bits;
      logic [7:0] expBits;
      int         firstReturn;

      //           start stop load seed   rdy   valid data   state  lock run
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 7'h01, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 7'h00, 1'b0, 1'b0, 8'h00, 7'h01, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 7'h05, 1'b0, 1'b0, 8'h00, 7'h05, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 7'h01, 1'b0, 1'b0, 8'h00, 7'h01, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 8'h00, 7'h01, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 8'h60, 7'h06, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 8'h28, 7'h14, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 7'h33, 1'b1, 1'b1, 8'h9E, 7'h79, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 8'h9E, 7'h79, 1'b1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b1, 8'h68, 7'h16, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1, 8'h68, 7'h16, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 8'h68, 7'h16, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b0, 1'b1, 8'h68, 7'h16, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 8'hAE, 7'h75, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 8'hAE, 7'h75, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; stop = 1'b0; seedLoad = 1'b0; seed = 7'h00; ready = 1'b0;
      start1 = 1'b0; ready1 = 1'b0;
      @(negedge clk);
      tick();
      checkOutput("reset valid",   64'(valid8),   64'd0);
      checkOutput("reset data",    64'(data8),    64'd0);
      checkOutput("reset state",   64'(state8),   64'h01);
      checkOutput("reset lockup",  64'(lockup8),  64'd0);
      checkOutput("reset running", 64'(running8), 64'd0);
      rst = 1'b0;

      runRows(0, 9);

      // Ten cycles of back-pressure: word, state and valid must all hold.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
         checkOutput($sformatf("hold%0d data", i),  64'(data8),  64'h68);
         checkOutput($sformatf("hold%0d state", i), 64'(state8), 64'h16);
         checkOutput($sformatf("hold%0d valid", i), 64'(valid8), 64'd1);
      end

      runRows(10, 14);

      // Stop together with start in IDLE: start wins and the stop is dropped,
      // so the first RUN handshake must not return to IDLE.
      applyStimulus(1'b1, 1'b1, 1'b0, 7'h00, 1'b0);
      checkOutput("idle start+stop running", 64'(running8), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
      checkOutput("prime->run valid", 64'(valid8), 64'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
      checkOutput("stale stop ignored valid", 64'(valid8), 64'd1);

      // Reset in the middle of a handshake.
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b1);
      checkOutput("rst mid-hs valid",   64'(valid8),   64'd0);
      checkOutput("rst mid-hs state",   64'(state8),   64'h01);
      checkOutput("rst mid-hs lockup",  64'(lockup8),  64'd0);
      checkOutput("rst mid-hs running", 64'(running8), 64'd0);
      checkOutput("autostart rst valid", 64'(validA), 64'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
      checkOutput("autostart first valid", 64'(validA), 64'd1);
      checkOutput("autostart first data",  64'(dataA),  64'h60);
      checkOutput("autostart state",       64'(stateA), 64'h06);
      checkOutput("manual stays idle",     64'(valid8), 64'd0);

      // Single-bit words: check the opening bit pattern and the period.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      ready1 = 1'b1;
      bits = 8'h00;
      expBits = 8'b0110_0000;
      firstReturn = 0;
      for (int gen = 1; gen <= 130; gen++) begin
         tick();
         if (gen <= 8) begin
            bits[gen-1] = data1[0];
         end
         if (firstReturn == 0 && state1 == 7'h01) begin
            firstReturn = gen;
         end
      end
      ready1 = 1'b0;
      checkOutput("nbits1 first 8 bits", 64'(bits), 64'(expBits));
      checkOutput("nbits1 period", 64'(firstReturn), 64'd127);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
